ifu_prefetch: RTL and testbench

//  Fetch unit with a prefetch buffer. It holds the fetch PC and issues

---
 rtl/ifu_prefetch.sv | 125 ++++++++++++
 tb/tb_ifu_prefetch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with a prefetch queue: issues sequential requests to an
// in-order memory port, queues returned words with their PCs, and flushes on redirect.
module ifu_prefetch #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 'h0000_3000,
  parameter int               DEPTH    = 4,
  parameter int               PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     redirect,
  input  logic [WIDTH-1:0]         redirect_pc,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [WIDTH-1:0]         req_addr,
  input  logic                     resp_valid,
  input  logic [WIDTH-1:0]         resp_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_ins,
  output logic [WIDTH-1:0]         out_pc,
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]      LIMIT = (CW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] STEP  = WIDTH'(PC_STEP);

  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    outstanding_q, outstanding_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] ins_mem_q [DEPTH];
  logic [WIDTH-1:0] ins_mem_d [DEPTH];
  logic [WIDTH-1:0] pc_mem_q  [DEPTH];
  logic [WIDTH-1:0] pc_mem_d  [DEPTH];

  logic        req_fire;
  logic        push;
  logic        pop;
  logic [CW:0] occupancy;

  // Queue slots are reserved for every in-flight request, so a response always fits.
  assign occupancy   = {1'b0, count_q} + {1'b0, outstanding_q};
  assign req_valid   = rst_n && !redirect && (occupancy < LIMIT);
  assign req_fire    = req_valid && req_ready;
  assign req_addr    = fetch_pc_q;
  assign out_valid   = (count_q != '0);
  assign out_ins     = ins_mem_q[rd_ptr_q];
  assign out_pc      = pc_mem_q[rd_ptr_q];
  assign outstanding = outstanding_q;

  assign push = !redirect && resp_valid && (drop_q == '0);
  assign pop  = !redirect && out_valid && out_ready;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    drop_d        = drop_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    ins_mem_d     = ins_mem_q;
    pc_mem_d      = pc_mem_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_valid);

    if (redirect) begin
      // Everything still in flight after this cycle's response is stale.
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      drop_d     = outstanding_d;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + STEP;
      end
      if (resp_valid && !push) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        ins_mem_d[wr_ptr_q] = resp_data;
        pc_mem_d[wr_ptr_q]  = resp_pc_q;
        wr_ptr_d            = wr_ptr_q + AW'(1);
        resp_pc_d           = resp_pc_q + STEP;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ins_mem_q[i] <= '0;
        pc_mem_q[i]  <= RESET_PC;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ins_mem_q     <= ins_mem_d;
      pc_mem_q      <= pc_mem_d;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: an in-order memory model with programmable
// latency answers requests, and every cycle the DUT is compared against expected behaviour.
module tb_ifu_prefetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_3000;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic [2:0]  outstanding;

  ifu_prefetch #(
    .WIDTH(32), .RESET_PC(RPC), .DEPTH(DEPTH), .PC_STEP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins), .out_pc(out_pc),
    .outstanding(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          total, bad;
  int          cyc_n, lat, cnt_m, drop_m, n_req, n_pop;
  bit          rand_lat;
  logic        rr, orr, rd;
  logic [31:0] rd_pc, exp_pc, fetch_m;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs at negedge, sample and update the model 1 time unit later.
  task automatic cyc();
    int   osz;
    int   l;
    logic exp_rv;
    @(negedge clk);
    osz = mq.size();
    chk("outstanding", 64'(outstanding), 64'(osz));
    chk("out_valid", 64'(out_valid), 64'(cnt_m != 0));
    redirect    = rd;
    redirect_pc = rd_pc;
    req_ready   = rr;
    out_ready   = orr;
    if (mq.size() > 0 && mq[0].due <= cyc_n) begin
      resp_valid = 1'b1;
      resp_data  = word(mq[0].a);
      void'(mq.pop_front());
    end else begin
      resp_valid = 1'b0;
      resp_data  = 32'h0;
    end
    #1;
    exp_rv = !rd && ((cnt_m + osz) < DEPTH);
    chk("req_valid", 64'(req_valid), 64'(exp_rv));
    if (rd) begin
      cnt_m   = 0;
      drop_m  = mq.size();
      exp_pc  = rd_pc;
      fetch_m = rd_pc;
    end else begin
      if (cnt_m != 0 && orr) begin
        chk("pop_pc", 64'(out_pc), 64'(exp_pc));
        chk("pop_ins", 64'(out_ins), 64'(word(exp_pc)));
        exp_pc = exp_pc + 32'd4;
        cnt_m--;
        n_pop++;
      end
      if (resp_valid) begin
        if (drop_m > 0) drop_m--;
        else cnt_m++;
      end
    end
    if (req_valid && rr) begin
      chk("req_addr", 64'(req_addr), 64'(fetch_m));
      fetch_m = fetch_m + 32'd4;
      l = rand_lat ? int'($urandom_range(1, 3)) : lat;
      mq.push_back('{a: req_addr, due: cyc_n + l});
      n_req++;
    end
    cyc_n++;
  endtask

  // Asserts reset wherever the caller is in the cycle, checks outputs at once, releases at a negedge.
  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    req_ready   = 1'b0;
    out_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_data   = 32'h0;
    rr = 1'b0; orr = 1'b0; rd = 1'b0; rd_pc = 32'h0;
    mq.delete();
    cnt_m = 0; drop_m = 0; n_req = 0;
    exp_pc = RPC; fetch_m = RPC;
    #1;
    chk("rst_req_valid", 64'(req_valid), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_ins", 64'(out_ins), 64'(0));
    chk("rst_out_pc", 64'(out_pc), 64'(RPC));
    chk("rst_req_addr", 64'(req_addr), 64'(RPC));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0; bad = 0; cyc_n = 0; n_pop = 0;
    lat = 1; rand_lat = 0;
    rst_n = 1'b1;
    #2;
    do_reset();

    // Streaming with a 1-cycle memory.
    lat = 1; rr = 1'b1; orr = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("t1_addr", 64'(req_addr), 64'(RPC + 32'(4 * k)));
      if (k >= 2) begin
        chk("t1_out_pc", 64'(out_pc), 64'(RPC + 32'(4 * (k - 2))));
        chk("t1_out_ins", 64'(out_ins), 64'(word(RPC + 32'(4 * (k - 2)))));
      end
    end

    // Decode stalled: exactly DEPTH requests, then drain.
    do_reset();
    lat = 1; rr = 1'b1; orr = 1'b0;
    repeat (8) cyc();
    chk("t2_nreq", 64'(n_req), 64'(4));
    chk("t2_req_valid", 64'(req_valid), 64'(0));
    chk("t2_full_valid", 64'(out_valid), 64'(1));
    chk("t2_head_pc", 64'(out_pc), 64'(RPC));
    orr = 1'b1;
    repeat (8) cyc();

    // Redirect with two responses in flight on a 3-cycle memory.
    do_reset();
    lat = 3; rr = 1'b1; orr = 1'b1;
    cyc(); cyc();
    rr = 1'b0; rd = 1'b1; rd_pc = 32'h0000_4000;
    cyc();
    chk("t3_no_req_on_redirect", 64'(req_valid), 64'(0));
    rd = 1'b0; rr = 1'b1;
    repeat (3) cyc();
    cyc();
    chk("t3_stale_dropped", 64'(out_valid), 64'(0));
    cyc();
    chk("t3_first_valid", 64'(out_valid), 64'(1));
    chk("t3_first_pc", 64'(out_pc), 64'(32'h0000_4000));
    chk("t3_first_ins", 64'(out_ins), 64'(word(32'h0000_4000)));

    // Redirect coinciding with a response and a pop.
    do_reset();
    lat = 1; rr = 1'b1; orr = 1'b0;
    repeat (3) cyc();
    rd = 1'b1; rd_pc = 32'h0000_5000; orr = 1'b1;
    cyc();
    rd = 1'b0;
    cyc();
    chk("t4_empty", 64'(out_valid), 64'(0));
    chk("t4_outstanding", 64'(outstanding), 64'(0));
    chk("t4_addr", 64'(req_addr), 64'(32'h0000_5000));
    cyc(); cyc();
    chk("t4_pc", 64'(out_pc), 64'(32'h0000_5000));

    // Long run: req_ready toggling, random decode stalls and latency, rare redirects.
    do_reset();
    rand_lat = 1; n_pop = 0;
    for (int i = 0; i < 1000; i++) begin
      rr    = (i % 2) == 0;
      orr   = 1'($urandom % 2);
      rd    = ($urandom % 64) == 0;
      rd_pc = $urandom & 32'hFFFF_FFFC;
      cyc();
    end
    rd = 1'b0;
    chk("t5_progress", 64'(n_pop > 100), 64'(1));

    // Asynchronous reset in the middle of a burst.
    do_reset();
    rand_lat = 0; lat = 2; rr = 1'b1; orr = 1'b1;
    repeat (6) cyc();
    #2;
    do_reset();
    lat = 2; rr = 1'b1; orr = 1'b1;
    cyc();
    chk("t6_restart_addr", 64'(req_addr), 64'(RPC));
    repeat (3) cyc();
    chk("t6_out_valid", 64'(out_valid), 64'(1));
    chk("t6_out_pc", 64'(out_pc), 64'(RPC));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
